// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 MUX: registered one-hot grant, select lines and valid,
// with a bounded hold time so a busy requester cannot starve the others.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic       Sel1,
  output logic       Sel0,
  output logic       Valid
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HoldOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [3:0] others;
  logic [2:0] pick_ptr;
  logic [2:0] pick_next;

  // Returns {found, index} of the first set bit of req, scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [3:0] rot;
    logic [1:0] off;
    for (int i = 0; i < 4; i++) begin
      rot[i] = req[start + 2'(i)];
    end
    off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    return {|rot, start + off};
  endfunction

  // While busy, sel_q is the current owner.
  assign others    = Req & ~(4'b0001 << sel_q);
  assign pick_ptr  = rr_pick(Req, ptr_q);
  assign pick_next = rr_pick(others, sel_q + 2'd1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    hold_d  = hold_q;

    unique case (state_q)
      StIdle: begin
        if (|Req) begin
          state_d = StBusy;
          grant_d = 4'b0001 << pick_ptr[1:0];
          sel_d   = pick_ptr[1:0];
          valid_d = 1'b1;
          hold_d  = HoldOne;
          ptr_d   = pick_ptr[1:0] + 2'd1;
        end else begin
          grant_d = 4'b0000;
          valid_d = 1'b0;
        end
      end
      StBusy: begin
        if (!Req[sel_q] || ((hold_q >= MaxHold) && (|others))) begin
          // Release or preemption; with the owner's bit low, others equals Req.
          if (pick_next[2]) begin
            grant_d = 4'b0001 << pick_next[1:0];
            sel_d   = pick_next[1:0];
            valid_d = 1'b1;
            hold_d  = HoldOne;
            ptr_d   = pick_next[1:0] + 2'd1;
          end else begin
            state_d = StIdle;
            grant_d = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q < MaxHold) begin
          hold_d = hold_q + HoldOne;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign Grant = grant_q;
  assign Sel1  = sel_q[1];
  assign Sel0  = sel_q[0];
  assign Valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: fixed vector table, a MAX_HOLD=1 sequence and random traffic
// checked against a queue-free behavioural model for both MAX_HOLD=4 and MAX_HOLD=1 instances.
module tb_mux_rr_arbiter;

  logic       Clk;
  logic       Reset;
  logic [3:0] Req;
  logic [3:0] grant4, grant1;
  logic       sel1_4, sel0_4, valid4;
  logic       sel1_1, sel0_1, valid1;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (Req),
    .Grant (grant4),
    .Sel1  (sel1_4),
    .Sel0  (sel0_4),
    .Valid (valid4)
  );

  mux_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (Req),
    .Grant (grant1),
    .Sel1  (sel1_1),
    .Sel0  (sel0_1),
    .Valid (valid1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  // Model state per instance: index 0 is MAX_HOLD=4, index 1 is MAX_HOLD=1.
  int m_owner[2];
  int m_hold[2];
  int m_ptr[2];
  int m_sel[2];
  int m_max[2];

  function automatic int first_req(input logic [3:0] r, input int s);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (s + i) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_give(input int k, input int w);
    m_owner[k] = w;
    m_sel[k]   = w;
    m_hold[k]  = 1;
    m_ptr[k]   = (w + 1) % 4;
  endtask

  task automatic model_step(input int k, input logic rst, input logic [3:0] r);
    int w;
    logic [3:0] oth;
    if (rst) begin
      m_owner[k] = -1;
      m_hold[k]  = 0;
      m_ptr[k]   = 0;
      m_sel[k]   = 0;
    end else if (m_owner[k] < 0) begin
      w = first_req(r, m_ptr[k]);
      if (w >= 0) model_give(k, w);
    end else begin
      oth = r;
      oth[m_owner[k]] = 1'b0;
      if (!r[m_owner[k]]) begin
        w = first_req(r, m_owner[k] + 1);
        if (w >= 0) model_give(k, w);
        else m_owner[k] = -1;
      end else if (m_hold[k] >= m_max[k] && oth != 4'b0000) begin
        model_give(k, first_req(oth, m_owner[k] + 1));
      end else if (m_hold[k] < m_max[k]) begin
        m_hold[k] = m_hold[k] + 1;
      end
    end
  endtask

  function automatic logic [6:0] model_out(input int k);
    logic [3:0] g;
    g = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
    return {g, 2'(m_sel[k]), (m_owner[k] >= 0)};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {grant,sel,valid} got %b_%b_%b expected %b_%b_%b at %0t", name,
               act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0], $time);
    end
  endtask

  // Drive one cycle, advance the model and compare both instances against it.
  task automatic tick(input logic rst, input logic [3:0] r);
    Reset = rst;
    Req   = r;
    @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, rst, r);
    check("model_hold4", {grant4, sel1_4, sel0_4, valid4}, model_out(0));
    check("model_hold1", {grant1, sel1_1, sel0_1, valid1}, model_out(1));
  endtask

  function automatic void add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] s, input logic v, input int n);
    vec_t e;
    e = '{rst: rst, req: r, grant: g, sel: s, valid: v};
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endfunction

  initial begin
    logic [3:0] r;
    logic       rst;

    m_max[0] = 4;
    m_max[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_hold[k]  = 0;
      m_ptr[k]   = 0;
      m_sel[k]   = 0;
    end
    Reset = 1'b1;
    Req   = 4'b0000;

    // Expected values below are for the MAX_HOLD=4 instance.
    add(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1);
    add(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 5);
    add(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 10);
    add(1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, 1);
    // Pointer is 3 after owner 2, so rotation starts at 3.
    add(1'b0, 4'b1111, 4'b1000, 2'b11, 1'b1, 4);
    add(1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1, 4);
    add(1'b0, 4'b1111, 4'b0010, 2'b01, 1'b1, 4);
    add(1'b0, 4'b1111, 4'b0100, 2'b10, 1'b1, 4);
    add(1'b0, 4'b1111, 4'b1000, 2'b11, 1'b1, 2);
    add(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1);
    add(1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1, 1);
    add(1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1, 3);
    add(1'b0, 4'b0011, 4'b0010, 2'b01, 1'b1, 2);
    add(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 1);
    add(1'b0, 4'b0110, 4'b0010, 2'b01, 1'b1, 1);
    add(1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0, 1);

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), {grant4, sel1_4, sel0_4, valid4},
            {vecs[i].grant, vecs[i].sel, vecs[i].valid});
    end

    // Strict per-cycle rotation on the MAX_HOLD=1 instance.
    tick(1'b1, 4'b0000);
    check("hold1_reset", {grant1, sel1_1, sel0_1, valid1}, 7'b0000_00_0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 4'b1010);
      if (i % 2 == 0) check("hold1_alt", {grant1, sel1_1, sel0_1, valid1}, 7'b0010_01_1);
      else            check("hold1_alt", {grant1, sel1_1, sel0_1, valid1}, 7'b1000_11_1);
    end

    // Random traffic; requests are held most cycles so hold limits actually bite.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 59) == 0);
      tick(rst, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
